// File: rtl/player_motion_ctrl_if.sv
// player_motion_ctrl_if: frame tick, key, collision and pause inputs
// plus the integrator command outputs; master drives inputs, slave is the DUT.
interface player_motion_ctrl_if;
  logic       startOfFrame;
  logic       keyLeftN;
  logic       keyRightN;
  logic       collision;
  logic       pauseReq;
  logic       moveLeftN;
  logic       moveRightN;
  logic [7:0] xSpeed;
  logic       paused;
  logic       stunned;

  modport master (
    output startOfFrame,
    output keyLeftN,
    output keyRightN,
    output collision,
    output pauseReq,
    input  moveLeftN,
    input  moveRightN,
    input  xSpeed,
    input  paused,
    input  stunned
  );

  modport slave (
    input  startOfFrame,
    input  keyLeftN,
    input  keyRightN,
    input  collision,
    input  pauseReq,
    output moveLeftN,
    output moveRightN,
    output xSpeed,
    output paused,
    output stunned
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame left/right arbitration, speed ramp,
// post-collision stun and pause state for the player position integrator.
// Ports: clk; resetN (async, active-low); bus (slave side of
// player_motion_ctrl_if: startOfFrame/keys/collision/pauseReq in,
// moveLeftN/moveRightN/xSpeed/paused/stunned out, all registered).
module player_motion_ctrl #(
  parameter int unsigned MIN_SPEED   = 4,
  parameter int unsigned ACCEL       = 2,
  parameter int unsigned MAX_SPEED   = 16,
  parameter int unsigned STUN_FRAMES = 8
) (
  input logic                 clk,
  input logic                 resetN,
  player_motion_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOVE_L = 3'd1,
    MOVE_R = 3'd2,
    STUN   = 3'd3,
    PAUSE  = 3'd4
  } state_t;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_t;

  localparam logic [7:0] MIN_V   = 8'(MIN_SPEED);
  localparam logic [7:0] ACC_V   = 8'(ACCEL);
  localparam logic [7:0] MAX_V   = 8'(MAX_SPEED);
  localparam logic [7:0] STUN_LD = 8'(STUN_FRAMES - 1);

  state_t     state;
  state_t     state_d;
  state_t     start_st;
  logic [7:0] speed;
  logic [7:0] speed_d;
  logic [7:0] start_spd;
  logic [7:0] cnt;
  logic [7:0] cnt_d;
  logic       pend;
  logic       pend_d;
  logic       key_l;
  logic       key_r;
  dir_t       last_dir;
  logic       press_l;
  logic       press_r;
  logic       want_l;
  logic       want_r;
  logic [8:0] sum;
  logic [7:0] ramp;
  logic       moving_d;

  // Key history: a press is the registered level going 1 -> 0.
  assign press_l = key_l & ~bus.keyLeftN;
  assign press_r = key_r & ~bus.keyRightN;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_l    <= 1'b1;
      key_r    <= 1'b1;
      last_dir <= DIR_R;
    end else begin
      key_l <= bus.keyLeftN;
      key_r <= bus.keyRightN;
      if (press_l && !press_r)
        last_dir <= DIR_L;
      else if (press_r && !press_l)
        last_dir <= DIR_R;
    end
  end

  // Both held: the most recently pressed key wins.
  assign want_l = ~key_l & (key_r | (last_dir == DIR_L));
  assign want_r = ~key_r & (key_l | (last_dir == DIR_R));

  // 9-bit sum so the ramp saturates instead of wrapping.
  assign sum  = {1'b0, speed} + {1'b0, ACC_V};
  assign ramp = (sum > {1'b0, MAX_V}) ? MAX_V : sum[7:0];

  // Where a tick would go if motion (re)started from rest.
  always_comb begin
    start_st  = IDLE;
    start_spd = '0;
    unique case (1'b1)
      want_l: begin
        start_st  = MOVE_L;
        start_spd = MIN_V;
      end
      want_r: begin
        start_st  = MOVE_R;
        start_spd = MIN_V;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    speed_d = speed;
    cnt_d   = cnt;
    pend_d  = pend | bus.collision;
    if (state == STUN || state == PAUSE)
      pend_d = 1'b0;
    if (bus.pauseReq) begin
      pend_d  = 1'b0;
      speed_d = '0;
      state_d = (state == PAUSE) ? IDLE : PAUSE;
    end else if (bus.startOfFrame) begin
      unique case (state)
        PAUSE: ;
        STUN: begin
          if (cnt == 8'd0) begin
            state_d = start_st;
            speed_d = start_spd;
          end else begin
            cnt_d = cnt - 8'd1;
          end
        end
        default: begin
          if (pend) begin
            state_d = STUN;
            speed_d = '0;
            cnt_d   = STUN_LD;
            pend_d  = 1'b0;
          end else if (start_st == IDLE) begin
            state_d = IDLE;
            speed_d = '0;
          end else if (start_st != state) begin
            state_d = start_st;
            speed_d = MIN_V;
          end else begin
            speed_d = ramp;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      speed <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_d;
      speed <= speed_d;
      cnt   <= cnt_d;
      pend  <= pend_d;
    end
  end

  assign moving_d = (state_d == MOVE_L) || (state_d == MOVE_R);

  // Outputs are flops decoded from the next state so they
  // track the state register exactly.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.moveLeftN  <= 1'b1;
      bus.moveRightN <= 1'b1;
      bus.xSpeed     <= '0;
      bus.paused     <= 1'b0;
      bus.stunned    <= 1'b0;
    end else begin
      bus.moveLeftN  <= (state_d != MOVE_L);
      bus.moveRightN <= (state_d != MOVE_R);
      bus.xSpeed     <= moving_d ? speed_d : 8'd0;
      bus.paused     <= (state_d == PAUSE);
      bus.stunned    <= (state_d == STUN);
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_player_motion_ctrl;
  localparam int MIN_SPEED   = 4;
  localparam int ACCEL       = 2;
  localparam int MAX_SPEED   = 16;
  localparam int STUN_FRAMES = 8;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  int   errors = 0;
  int   checks = 0;

  player_motion_ctrl_if bus();

  player_motion_ctrl #(
    .MIN_SPEED  (MIN_SPEED),
    .ACCEL      (ACCEL),
    .MAX_SPEED  (MAX_SPEED),
    .STUN_FRAMES(STUN_FRAMES)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: direction -1/0/+1, speed, frames of stun left.
  int m_dir;
  int m_speed;
  int m_stun;
  int m_last;
  bit m_paused;
  bit m_pend;
  bit m_prevL;
  bit m_prevR;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir    = 0;
    m_speed  = 0;
    m_stun   = 0;
    m_last   = 1;
    m_paused = 0;
    m_pend   = 0;
    m_prevL  = 1;
    m_prevR  = 1;
  endtask

  task automatic model_step();
    int des;
    bit hl;
    bit hr;
    bit pl;
    bit pr;
    bit np;
    hl = !m_prevL;
    hr = !m_prevR;
    if (hl && !hr) des = -1;
    else if (hr && !hl) des = 1;
    else if (hl && hr) des = m_last;
    else des = 0;
    pl = m_prevL && !bus.keyLeftN;
    pr = m_prevR && !bus.keyRightN;
    if (pl && !pr) m_last = -1;
    else if (pr && !pl) m_last = 1;
    m_prevL = bus.keyLeftN;
    m_prevR = bus.keyRightN;
    if (bus.pauseReq) begin
      m_pend   = 0;
      m_paused = !m_paused;
      m_stun   = 0;
      m_dir    = 0;
      m_speed  = 0;
    end else begin
      np = (m_paused || m_stun > 0) ? 1'b0 : (m_pend || bus.collision);
      if (bus.startOfFrame && !m_paused) begin
        if (m_stun > 0) begin
          m_stun--;
          if (m_stun == 0) begin
            m_dir   = des;
            m_speed = (des != 0) ? MIN_SPEED : 0;
          end
        end else if (m_pend) begin
          m_stun  = STUN_FRAMES;
          m_dir   = 0;
          m_speed = 0;
          np      = 0;
        end else if (des == 0) begin
          m_dir   = 0;
          m_speed = 0;
        end else if (des != m_dir) begin
          m_dir   = des;
          m_speed = MIN_SPEED;
        end else begin
          m_speed = (m_speed + ACCEL > MAX_SPEED) ? MAX_SPEED : m_speed + ACCEL;
        end
      end
      m_pend = np;
    end
  endtask

  // Compare on the falling edge, then advance the model with the
  // inputs the DUT will sample on the next rising edge.
  always @(negedge clk) begin
    if (!resetN) model_reset();
    chk("cmp_moveLeftN", int'(bus.moveLeftN), (m_dir == -1) ? 0 : 1);
    chk("cmp_moveRightN", int'(bus.moveRightN), (m_dir == 1) ? 0 : 1);
    chk("cmp_xSpeed", int'(bus.xSpeed), m_speed);
    chk("cmp_paused", int'(bus.paused), int'(m_paused));
    chk("cmp_stunned", int'(bus.stunned), (m_stun > 0) ? 1 : 0);
    if (resetN) model_step();
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    bus.startOfFrame = 1'b1;
    cyc(1);
    bus.startOfFrame = 1'b0;
  endtask

  task automatic pulse_pause();
    bus.pauseReq = 1'b1;
    cyc(1);
    bus.pauseReq = 1'b0;
  endtask

  task automatic pulse_coll();
    bus.collision = 1'b1;
    cyc(1);
    bus.collision = 1'b0;
  endtask

  task automatic chk_out(string name, int ml, int mr, int sp, int pa, int st);
    chk({name, "_moveLeftN"}, int'(bus.moveLeftN), ml);
    chk({name, "_moveRightN"}, int'(bus.moveRightN), mr);
    chk({name, "_xSpeed"}, int'(bus.xSpeed), sp);
    chk({name, "_paused"}, int'(bus.paused), pa);
    chk({name, "_stunned"}, int'(bus.stunned), st);
  endtask

  int ramp_exp[8] = '{4, 6, 8, 10, 12, 14, 16, 16};

  initial begin
    bus.startOfFrame = 1'b0;
    bus.keyLeftN     = 1'b1;
    bus.keyRightN    = 1'b1;
    bus.collision    = 1'b0;
    bus.pauseReq     = 1'b0;
    #1 resetN = 1'b0;
    cyc(3);
    chk_out("reset", 1, 1, 0, 0, 0);
    resetN = 1'b1;
    cyc(2);

    // Saturating ramp on left.
    bus.keyLeftN = 1'b0;
    cyc(2);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("ramp", 0, 1, ramp_exp[i], 0, 0);
      cyc(2);
    end

    // Release, then reversal and release of the newer key.
    bus.keyLeftN = 1'b1;
    cyc(2);
    tick();
    chk_out("release", 1, 1, 0, 0, 0);
    bus.keyLeftN = 1'b0;
    cyc(2);
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc(2);
    end
    chk("rev_pre_speed", int'(bus.xSpeed), 8);
    bus.keyRightN = 1'b0;
    cyc(2);
    tick();
    chk_out("reverse", 1, 0, 4, 0, 0);
    bus.keyRightN = 1'b1;
    cyc(2);
    tick();
    chk_out("back_left", 0, 1, 4, 0, 0);

    // Stun while right stays held.
    bus.keyLeftN  = 1'b1;
    bus.keyRightN = 1'b0;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      tick();
      cyc(2);
    end
    chk("stun_pre_speed", int'(bus.xSpeed), 10);
    cyc(3);
    pulse_coll();
    cyc(2);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out("stun", 1, 1, 0, 0, 1);
      cyc(2);
    end
    tick();
    chk_out("stun_exit", 1, 0, 4, 0, 0);
    cyc(2);

    // Pause and resume; collision while paused is dropped.
    tick();
    cyc(2);
    pulse_pause();
    chk_out("pause", 1, 1, 0, 1, 0);
    cyc(2);
    pulse_coll();
    cyc(2);
    tick();
    cyc(2);
    chk_out("pause_hold", 1, 1, 0, 1, 0);
    pulse_pause();
    chk_out("unpause", 1, 1, 0, 0, 0);
    cyc(2);
    tick();
    chk_out("resume", 1, 0, 4, 0, 0);
    cyc(2);

    // Pending collision dropped by pause arriving with a tick.
    pulse_coll();
    cyc(2);
    bus.pauseReq     = 1'b1;
    bus.startOfFrame = 1'b1;
    cyc(1);
    bus.pauseReq     = 1'b0;
    bus.startOfFrame = 1'b0;
    chk_out("prio_pause", 1, 1, 0, 1, 0);
    cyc(2);
    pulse_pause();
    cyc(2);
    tick();
    chk_out("prio_nostun", 1, 0, 4, 0, 0);
    cyc(2);
    tick();
    chk_out("prio_ramp", 1, 0, 6, 0, 0);
    cyc(2);

    // Asynchronous reset in the middle of a stun.
    pulse_coll();
    cyc(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      cyc(2);
    end
    chk("pre_reset_stunned", int'(bus.stunned), 1);
    #2 resetN = 1'b0;
    #1;
    chk_out("async_reset", 1, 1, 0, 0, 0);
    bus.keyRightN = 1'b1;
    cyc(2);
    resetN = 1'b1;
    cyc(2);
    tick();
    chk_out("post_reset", 1, 1, 0, 0, 0);
    cyc(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.startOfFrame = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) bus.keyLeftN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.keyRightN = 1'($urandom_range(0, 1));
      bus.collision = ($urandom_range(0, 29) == 0);
      bus.pauseReq  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 resetN = 1'b0;
        #1;
        chk_out("rand_reset", 1, 1, 0, 0, 0);
        cyc(2);
        resetN = 1'b1;
      end
      cyc(1);
    end
    bus.startOfFrame = 1'b0;
    bus.collision    = 1'b0;
    bus.pauseReq     = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
